// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_FETCH  = 2'd1,
    OWN_DLOAD  = 2'd2,
    OWN_DSTORE = 2'd3
  } owner_t;

  localparam logic [3:0] WE_NONE  = 4'b0000;
  localparam int         STREAK_W = 4;

  // Any asserted byte enable makes a data command a store.
  function automatic owner_t data_owner(input logic [3:0] we);
    return (we == WE_NONE) ? OWN_DLOAD : OWN_DSTORE;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant select for the shared memory port: data wins ties until the data
// streak reaches the burst limit, then one fetch is forced through.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                if_req_i,
  input  logic                d_req_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic                if_gnt_o,
  output logic                d_gnt_o
);

  localparam logic [STREAK_W-1:0] BURST_LIMIT = STREAK_W'(MAX_DATA_BURST);

  logic fetch_starved_s;

  assign fetch_starved_s = if_req_i && (streak_i == BURST_LIMIT);

  always_comb begin
    if_gnt_o = 1'b0;
    d_gnt_o  = 1'b0;
    if (d_req_i && !fetch_starved_s) begin
      d_gnt_o = 1'b1;
    end else if (if_req_i) begin
      if_gnt_o = 1'b1;
    end else begin
      if_gnt_o = 1'b0;
      d_gnt_o  = 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port BRAM arbiter between fetch and load/store: one command per cycle,
// read data routed back to the owner of the previous cycle's command.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  output logic                  if_stall,
  input  logic                  d_req,
  input  logic [3:0]            d_we,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  m_en,
  output logic [3:0]            m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_wdata,
  input  logic [31:0]           m_rdata
);

  localparam logic [STREAK_W-1:0] BURST_LIMIT = STREAK_W'(MAX_DATA_BURST);

  logic                if_req_s;
  logic                d_req_s;
  owner_t              owner_q;
  owner_t              owner_d;
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                flush_q;
  logic                unused_s;

  // Requests are ignored while reset is held so no command is issued until it drops.
  assign if_req_s = if_req & ~rst;
  assign d_req_s  = d_req & ~rst;

  mem_arb_grant #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) u_grant (
    .if_req_i (if_req_s),
    .d_req_i  (d_req_s),
    .streak_i (streak_q),
    .if_gnt_o (if_gnt),
    .d_gnt_o  (d_gnt)
  );

  assign if_stall = if_req & ~if_gnt;

  always_comb begin
    streak_d = streak_q;
    if (!if_req_s || if_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q != BURST_LIMIT)) begin
      streak_d = streak_q + 1'b1;
    end else begin
      streak_d = streak_q;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_FETCH;
    end else if (d_gnt) begin
      owner_d = data_owner(d_we);
    end else begin
      owner_d = OWN_NONE;
    end
  end

  // flush_q remembers a flush seen in the cycle a fetch was granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      streak_q <= '0;
      flush_q  <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
      flush_q  <= flush;
    end
  end

  // Word address is taken from the byte address; upper bits wrap.
  always_comb begin
    m_en    = if_gnt | d_gnt;
    m_we    = WE_NONE;
    m_addr  = '0;
    m_wdata = 32'h0000_0000;
    if (d_gnt) begin
      m_we    = d_we;
      m_addr  = d_addr[ADDR_WIDTH+1:2];
      m_wdata = d_wdata;
    end else if (if_gnt) begin
      m_addr  = if_addr[ADDR_WIDTH+1:2];
    end else begin
      m_we    = WE_NONE;
    end
  end

  always_comb begin
    if_rvalid = (owner_q == OWN_FETCH) && !flush_q && !flush;
    d_rvalid  = (owner_q == OWN_DLOAD);
    if_rdata  = if_rvalid ? m_rdata : 32'h0000_0000;
    d_rdata   = d_rvalid ? m_rdata : 32'h0000_0000;
  end

  assign unused_s = ^{if_addr[31:ADDR_WIDTH+2], if_addr[1:0],
                      d_addr[31:ADDR_WIDTH+2], d_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, async reset sequence,
// then random traffic against a history-based reference model.
module tb_mem_port_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en;
  logic [3:0]  m_we;
  logic [11:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_WIDTH(12), .MAX_DATA_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        flush;
    logic [31:0] m_rdata;
    logic        e_ig;
    logic        e_dg;
    logic [11:0] e_maddr;
    logic        e_irv;
    logic [31:0] e_ird;
    logic        e_drv;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
      input logic ir, input logic [31:0] ia, input logic dr, input logic [3:0] dw,
      input logic [31:0] da, input logic [31:0] dd, input logic fl, input logic [31:0] mr,
      input logic eig, input logic edg, input logic [11:0] ema,
      input logic eirv, input logic [31:0] eird, input logic edrv, input logic [31:0] edrd);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
    v.d_wdata = dd; v.flush = fl; v.m_rdata = mr; v.e_ig = eig; v.e_dg = edg;
    v.e_maddr = ema; v.e_irv = eirv; v.e_ird = eird; v.e_drv = edrv; v.e_drd = edrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 4'h0;
    d_addr = 32'h0; d_wdata = 32'h0; flush = 1'b0; m_rdata = 32'h0;
  endtask

  task automatic check_cycle(input string tag, input logic eig, input logic edg,
                             input logic [11:0] emaddr, input logic eirv, input logic [31:0] eird,
                             input logic edrv, input logic [31:0] edrd);
    chk({tag, ".if_gnt"}, {63'd0, if_gnt}, {63'd0, eig});
    chk({tag, ".d_gnt"}, {63'd0, d_gnt}, {63'd0, edg});
    chk({tag, ".if_stall"}, {63'd0, if_stall}, {63'd0, if_req & ~eig});
    chk({tag, ".m_en"}, {63'd0, m_en}, {63'd0, eig | edg});
    chk({tag, ".m_we"}, {60'd0, m_we}, {60'd0, (edg ? d_we : 4'h0)});
    if (eig || edg) begin
      chk({tag, ".m_addr"}, {52'd0, m_addr}, {52'd0, emaddr});
      chk({tag, ".m_wdata"}, {32'd0, m_wdata}, {32'd0, (edg ? d_wdata : 32'h0)});
    end
    chk({tag, ".if_rvalid"}, {63'd0, if_rvalid}, {63'd0, eirv});
    chk({tag, ".if_rdata"}, {32'd0, if_rdata}, {32'd0, eird});
    chk({tag, ".d_rvalid"}, {63'd0, d_rvalid}, {63'd0, edrv});
    chk({tag, ".d_rdata"}, {32'd0, d_rdata}, {32'd0, edrd});
  endtask

  initial begin
    bit          hist[$];
    int          prev_kind;
    bit          prev_flush;
    int          run;
    logic        eig, edg, eirv, edrv;
    logic [11:0] ema;

    rst = 1'b1;
    set_idle();
    #8;
    m_rdata = 32'hFFFF_FFFF;
    #1;
    chk("reset.if_rvalid", {63'd0, if_rvalid}, 64'd0);
    chk("reset.d_rvalid", {63'd0, d_rvalid}, 64'd0);
    chk("reset.if_rdata", {32'd0, if_rdata}, 64'd0);
    chk("reset.d_rdata", {32'd0, d_rdata}, 64'd0);
    #3;
    rst = 1'b0;
    m_rdata = 32'h0;

    // Directed table: fields are inputs, then grants, m_addr, fetch return, data return.
    vecs.push_back(mk(1, 32'h10, 0, 4'h0, 32'h0,    32'h0,    0, 32'h0,         1, 0, 12'h004, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,  0, 4'h0, 32'h0,    32'h0,    0, 32'hDEADBEEF,  0, 0, 12'h000, 1, 32'hDEADBEEF,  0, 32'h0));
    vecs.push_back(mk(0, 32'h0,  1, 4'h3, 32'h20,   32'h1234, 0, 32'h0,         0, 1, 12'h008, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,  1, 4'h0, 32'h20,   32'h0,    0, 32'h55,        0, 1, 12'h008, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,  0, 4'h0, 32'h0,    32'h0,    0, 32'h1234,      0, 0, 12'h000, 0, 32'h0,         1, 32'h1234));
    vecs.push_back(mk(0, 32'h0,  1, 4'h0, 32'h4003, 32'h0,    0, 32'h77,        0, 1, 12'h000, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,  0, 4'h0, 32'h0,    32'h0,    0, 32'hAA,        0, 0, 12'h000, 0, 32'h0,         1, 32'hAA));
    vecs.push_back(mk(1, 32'h40, 0, 4'h0, 32'h0,    32'h0,    0, 32'h0,         1, 0, 12'h010, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,  0, 4'h0, 32'h0,    32'h0,    1, 32'h99,        0, 0, 12'h000, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(1, 32'h44, 0, 4'h0, 32'h0,    32'h0,    0, 32'h0,         1, 0, 12'h011, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,  0, 4'h0, 32'h0,    32'h0,    0, 32'h1111,      0, 0, 12'h000, 1, 32'h1111,      0, 32'h0));
    vecs.push_back(mk(1, 32'h8,  0, 4'h0, 32'h0,    32'h0,    1, 32'h0,         1, 0, 12'h002, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,  0, 4'h0, 32'h0,    32'h0,    0, 32'h22,        0, 0, 12'h000, 0, 32'h0,         0, 32'h0));
    // Both requesters held for 8 cycles: D,D,D,D,F,D,D,D.
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mk(1, 32'h100, 1, 4'h0, 32'h200, 32'h0, 0, 32'hC0 + 32'(k),
                        (k == 4), (k != 4), ((k == 4) ? 12'h040 : 12'h080),
                        (k == 5), ((k == 5) ? 32'hC5 : 32'h0),
                        (k >= 1 && k != 5), ((k >= 1 && k != 5) ? 32'hC0 + 32'(k) : 32'h0)));
    end
    vecs.push_back(mk(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 32'hC8, 0, 0, 12'h000, 0, 32'h0, 1, 32'hC8));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr; d_req = vecs[i].d_req;
      d_we = vecs[i].d_we; d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      flush = vecs[i].flush; m_rdata = vecs[i].m_rdata;
      @(negedge clk);
      check_cycle($sformatf("vec%0d", i), vecs[i].e_ig, vecs[i].e_dg, vecs[i].e_maddr,
                  vecs[i].e_irv, vecs[i].e_ird, vecs[i].e_drv, vecs[i].e_drd);
    end

    // Saturate the streak with loads, then reset asynchronously mid-cycle.
    for (int k = 0; k < MAXB; k++) begin
      @(posedge clk);
      #1;
      set_idle();
      if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_addr = 32'h300;
      @(negedge clk);
      chk($sformatf("pre_rst.d_gnt%0d", k), {63'd0, d_gnt}, 64'd1);
    end
    @(posedge clk);
    #1;
    set_idle();
    m_rdata = 32'hBEEF_0001;
    chk("pre_rst.d_rvalid", {63'd0, d_rvalid}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("in_rst.d_rvalid", {63'd0, d_rvalid}, 64'd0);
    chk("in_rst.d_rdata", {32'd0, d_rdata}, 64'd0);
    #1;
    rst = 1'b0;
    if_req = 1'b1; d_req = 1'b1; d_addr = 32'h300;
    @(negedge clk);
    chk("post_rst.d_gnt", {63'd0, d_gnt}, 64'd1);
    chk("post_rst.if_gnt", {63'd0, if_gnt}, 64'd0);
    chk("post_rst.d_rvalid", {63'd0, d_rvalid}, 64'd0);

    @(posedge clk);
    #1;
    set_idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;

    // Random traffic; model tracks recent cycles where data won while fetch waited.
    prev_kind  = 0;
    prev_flush = 1'b0;
    hist.delete();
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      if_req  = ($urandom_range(9, 0) < 6);
      d_req   = ($urandom_range(9, 0) < 6);
      if_addr = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_we    = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
      flush   = ($urandom_range(99, 0) < 15);
      m_rdata = $urandom;

      run = 0;
      for (int j = hist.size() - 1; j >= 0; j--) begin
        if (!hist[j]) break;
        run++;
      end
      eig = 1'b0;
      edg = 1'b0;
      if (d_req && !(if_req && run >= MAXB)) edg = 1'b1;
      else if (if_req) eig = 1'b1;
      ema  = edg ? d_addr[13:2] : if_addr[13:2];
      eirv = (prev_kind == 1) && !prev_flush && !flush;
      edrv = (prev_kind == 2);
      @(negedge clk);
      check_cycle($sformatf("rnd%0d", c), eig, edg, ema,
                  eirv, (eirv ? m_rdata : 32'h0), edrv, (edrv ? m_rdata : 32'h0));

      hist.push_back(edg && if_req);
      if (hist.size() > 32) void'(hist.pop_front());
      prev_kind  = eig ? 1 : (edg ? ((d_we == 4'h0) ? 2 : 3) : 0);
      prev_flush = flush;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
